// File: rtl/detector_frame_scheduler.sv
// Round-robin scheduler that time-shares one external "1101" Mealy detector
// among N_CH serial requesters, one fixed-length frame at a time.
module detector_frame_scheduler #(
   parameter  int unsigned N_CH      = 4,
   parameter  int unsigned FRAME_LEN = 16,
   parameter  int unsigned CNT_W     = 5,
   localparam int unsigned CH_W      = $clog2(N_CH)
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic [N_CH-1:0]   req,
   input  logic [N_CH-1:0]   bit_in,
   input  logic              det_z,
   output logic              det_w,
   output logic              det_clr,
   output logic [N_CH-1:0]   grant,
   output logic              busy,
   output logic              done,
   output logic [CH_W-1:0]   done_ch,
   output logic [CNT_W-1:0]  hit_count,
   output logic              aborted
);

   localparam int unsigned     BC_W     = $clog2(FRAME_LEN);
   localparam logic [BC_W-1:0] LAST_BIT = BC_W'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0] ACC_MAX = '1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CLEAR  = 2'd1,
      S_RUN    = 2'd2,
      S_REPORT = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [N_CH-1:0]   grant_q, grant_d;
   logic [CH_W-1:0]   sel_q, sel_d;
   logic [CH_W-1:0]   rr_q, rr_d;
   logic [BC_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]  acc_q, acc_d;
   logic              det_clr_q, det_clr_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;
   logic [CH_W-1:0]   done_ch_q, done_ch_d;
   logic [CNT_W-1:0]  hit_count_q, hit_count_d;
   logic              aborted_q, aborted_d;

   logic              pick_found;
   logic [CH_W-1:0]   pick_idx;
   logic [CH_W-1:0]   scan_idx;
   logic              to_report;

   // First requester after the last-served channel, wrapping around
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      scan_idx   = '0;
      for (int unsigned i = 1; i <= N_CH; i++) begin
         scan_idx = CH_W'((32'(rr_q) + i) % N_CH);
         if (!pick_found && req[scan_idx]) begin
            pick_found = 1'b1;
            pick_idx   = scan_idx;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      sel_d       = sel_q;
      rr_d        = rr_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      det_clr_d   = 1'b0;
      done_d      = 1'b0;
      busy_d      = busy_q;
      done_ch_d   = done_ch_q;
      hit_count_d = hit_count_q;
      aborted_d   = aborted_q;
      to_report   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (pick_found) begin
               grant_d           = '0;
               grant_d[pick_idx] = 1'b1;
               sel_d             = pick_idx;
               rr_d              = pick_idx;
               det_clr_d         = 1'b1;
               busy_d            = 1'b1;
               state_d           = S_CLEAR;
            end
         end
         S_CLEAR: begin
            cnt_d   = '0;
            acc_d   = '0;
            state_d = S_RUN;
         end
         S_RUN: begin
            // A dropped request ends the frame without counting this cycle
            if (!req[sel_q]) begin
               to_report = 1'b1;
               aborted_d = 1'b1;
            end else begin
               cnt_d = cnt_q + BC_W'(1);
               if (det_z && (acc_q != ACC_MAX)) begin
                  acc_d = acc_q + CNT_W'(1);
               end
               if (cnt_q == LAST_BIT) begin
                  to_report = 1'b1;
                  aborted_d = 1'b0;
               end
            end
            if (to_report) begin
               state_d     = S_REPORT;
               done_d      = 1'b1;
               hit_count_d = acc_d;
               done_ch_d   = sel_q;
            end
         end
         S_REPORT: begin
            grant_d = '0;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q     <= S_IDLE;
         grant_q     <= '0;
         sel_q       <= '0;
         rr_q        <= CH_W'(N_CH - 1);
         cnt_q       <= '0;
         acc_q       <= '0;
         det_clr_q   <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_ch_q   <= '0;
         hit_count_q <= '0;
         aborted_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         sel_q       <= sel_d;
         rr_q        <= rr_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         det_clr_q   <= det_clr_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         done_ch_q   <= done_ch_d;
         hit_count_q <= hit_count_d;
         aborted_q   <= aborted_d;
      end
   end

   // Outside RUN the detector sees zeros and stays in its default state
   assign det_w     = (state_q == S_RUN) ? bit_in[sel_q] : 1'b0;
   assign det_clr   = det_clr_q;
   assign grant     = grant_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign done_ch   = done_ch_q;
   assign hit_count = hit_count_q;
   assign aborted   = aborted_q;

endmodule

// File: tb/tb_detector_frame_scheduler.sv
// Directed bench for detector_frame_scheduler with a behavioural 1101 detector;
// a second instance with CNT_W=2 shares the stimulus to exercise saturation.
module tb_detector_frame_scheduler;

   logic       Clock;
   logic       Reset;
   logic [3:0] req;
   logic [3:0] bit_in;

   logic       det_z, det_w, det_clr, busy, done, aborted;
   logic [3:0] grant;
   logic [1:0] done_ch;
   logic [4:0] hit_count;

   logic       s_det_z, s_det_w, s_det_clr, s_busy, s_done, s_aborted;
   logic [3:0] s_grant;
   logic [1:0] s_done_ch;
   logic [1:0] s_hit_count;

   int errors = 0;
   int checks = 0;

   detector_frame_scheduler #(.N_CH(4), .FRAME_LEN(16), .CNT_W(5)) dut (
      .Clock(Clock), .Reset(Reset), .req(req), .bit_in(bit_in), .det_z(det_z),
      .det_w(det_w), .det_clr(det_clr), .grant(grant), .busy(busy), .done(done),
      .done_ch(done_ch), .hit_count(hit_count), .aborted(aborted)
   );

   detector_frame_scheduler #(.N_CH(4), .FRAME_LEN(16), .CNT_W(2)) dut_sat (
      .Clock(Clock), .Reset(Reset), .req(req), .bit_in(bit_in), .det_z(s_det_z),
      .det_w(s_det_w), .det_clr(s_det_clr), .grant(s_grant), .busy(s_busy), .done(s_done),
      .done_ch(s_done_ch), .hit_count(s_hit_count), .aborted(s_aborted)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Non-overlapping 1101 detector: states idle, "1", "11", "110"
   function automatic logic [1:0] det_next(input logic [1:0] s, input logic w);
      case (s)
         2'd0:    return w ? 2'd1 : 2'd0;
         2'd1:    return w ? 2'd2 : 2'd0;
         2'd2:    return w ? 2'd0 : 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   logic [1:0] ds, s_ds;
   logic       det_rst, s_det_rst;
   assign det_rst   = Reset | det_clr;
   assign s_det_rst = Reset | s_det_clr;
   assign det_z     = (ds == 2'd3) && det_w;
   assign s_det_z   = (s_ds == 2'd3) && s_det_w;

   always @(posedge Clock or posedge det_rst) begin
      if (det_rst) ds <= 2'd0;
      else         ds <= det_next(ds, det_w);
   end

   always @(posedge Clock or posedge s_det_rst) begin
      if (s_det_rst) s_ds <= 2'd0;
      else           s_ds <= det_next(s_ds, s_det_w);
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, want finish before time limit");
      $fatal(1);
   end

   task automatic apply_reset();
      Reset  = 1'b1;
      req    = 4'b0000;
      bit_in = 4'b0000;
      repeat (2) @(posedge Clock);
      @(negedge Clock);
      Reset = 1'b0;
   endtask

   // One complete frame starting from IDLE at a falling edge
   task automatic run_frame(input string name, input logic [1:0] ch, input logic [3:0] req_v,
                            input logic [15:0] pat, input logic [4:0] exp_hits);
      logic [3:0]  g;
      logic [15:0] sh;
      logic        b;
      g      = 4'b0001 << ch;
      sh     = pat;
      req    = req_v;
      bit_in = 4'hF;
      @(posedge Clock); @(negedge Clock);
      checks++; if (grant !== g) begin errors++; $display("FAIL %s_grant: got %b want %b", name, grant, g); end
      checks++; if (det_clr !== 1'b1) begin errors++; $display("FAIL %s_clr_pulse: got %b want 1", name, det_clr); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy_clear: got %b want 1", name, busy); end
      checks++; if (det_w !== 1'b0) begin errors++; $display("FAIL %s_clear_det_w: got %b want 0", name, det_w); end
      @(posedge Clock); @(negedge Clock);
      checks++; if (det_clr !== 1'b0) begin errors++; $display("FAIL %s_clr_end: got %b want 0", name, det_clr); end
      for (int j = 0; j < 16; j++) begin
         b      = sh[15];
         sh     = sh << 1;
         bit_in = b ? g : ~g;
         #1;
         checks++; if (det_w !== b) begin errors++; $display("FAIL %s_det_w bit %0d: got %b want %b", name, j, det_w, b); end
         checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s_done_early bit %0d: got %b want 0", name, j, done); end
         @(posedge Clock); @(negedge Clock);
      end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL %s_done: got %b want 1", name, done); end
      checks++; if (hit_count !== exp_hits) begin errors++; $display("FAIL %s_hits: got %0d want %0d", name, hit_count, exp_hits); end
      checks++; if (done_ch !== ch) begin errors++; $display("FAIL %s_done_ch: got %0d want %0d", name, done_ch, ch); end
      checks++; if (aborted !== 1'b0) begin errors++; $display("FAIL %s_aborted: got %b want 0", name, aborted); end
      checks++; if (grant !== g) begin errors++; $display("FAIL %s_grant_report: got %b want %b", name, grant, g); end
      bit_in = 4'b0000;
      @(posedge Clock); @(negedge Clock);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s_done_pulse: got %b want 0", name, done); end
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL %s_grant_release: got %b want 0000", name, grant); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_idle: got %b want 0", name, busy); end
      checks++; if (hit_count !== exp_hits) begin errors++; $display("FAIL %s_hits_hold: got %0d want %0d", name, hit_count, exp_hits); end
   endtask

   task automatic test_reset();
      Reset  = 1'b0;
      req    = 4'b0000;
      bit_in = 4'b0000;
      #1 Reset = 1'b1;
      #1;
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b want 0000", grant); end
      checks++; if ({det_clr, done, busy, aborted, det_w} !== 5'b00000) begin errors++; $display("FAIL reset_flags: got %b want 00000", {det_clr, done, busy, aborted, det_w}); end
      checks++; if (hit_count !== 5'd0) begin errors++; $display("FAIL reset_hits: got %0d want 0", hit_count); end
      checks++; if (done_ch !== 2'd0) begin errors++; $display("FAIL reset_done_ch: got %0d want 0", done_ch); end
      @(posedge Clock); @(negedge Clock);
      Reset = 1'b0;
      @(posedge Clock); @(negedge Clock);
      checks++; if ({grant, busy, det_clr} !== 6'b000000) begin errors++; $display("FAIL idle_no_req: got %b want 000000", {grant, busy, det_clr}); end
   endtask

   task automatic test_single();
      run_frame("single", 2'd0, 4'b0001, 16'b1101_1101_0000_0000, 5'd2);
   endtask

   task automatic test_all_channels();
      apply_reset();
      for (int c = 0; c < 4; c++) begin
         run_frame("all", 2'(c), 4'b1111, 16'b1101_0000_0000_0000, 5'd1);
      end
   endtask

   task automatic test_rr_wrap();
      apply_reset();
      run_frame("rr_ch2", 2'd2, 4'b0100, 16'b0110_1001_1010_1101, 5'd3);
      run_frame("rr_wrap", 2'd0, 4'b0101, 16'b1010_1100_1101_0000, 5'd1);
      run_frame("rr_next", 2'd2, 4'b0101, 16'b0000_0000_0000_0000, 5'd0);
   endtask

   task automatic test_abort();
      logic [15:0] sh;
      sh     = 16'b1101_1000_0000_0000;
      req    = 4'b0010;
      bit_in = 4'b0000;
      @(posedge Clock); @(negedge Clock);
      checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL abort_grant: got %b want 0010", grant); end
      @(posedge Clock); @(negedge Clock);
      for (int j = 0; j < 5; j++) begin
         bit_in = sh[15] ? 4'b0010 : 4'b1101;
         sh     = sh << 1;
         @(posedge Clock); @(negedge Clock);
      end
      req    = 4'b0000;
      bit_in = 4'b0010;
      @(posedge Clock); @(negedge Clock);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL abort_done: got %b want 1", done); end
      checks++; if (aborted !== 1'b1) begin errors++; $display("FAIL abort_flag: got %b want 1", aborted); end
      checks++; if (hit_count !== 5'd1) begin errors++; $display("FAIL abort_hits: got %0d want 1", hit_count); end
      checks++; if (done_ch !== 2'd1) begin errors++; $display("FAIL abort_done_ch: got %0d want 1", done_ch); end
      bit_in = 4'b0000;
      @(posedge Clock); @(negedge Clock);
      checks++; if ({grant, done, busy} !== 6'b000000) begin errors++; $display("FAIL abort_release: got %b want 000000", {grant, done, busy}); end
      checks++; if (aborted !== 1'b1) begin errors++; $display("FAIL abort_hold: got %b want 1", aborted); end
   endtask

   task automatic test_reset_mid_run();
      logic [15:0] sh;
      sh     = 16'b1101_1101_0000_0000;
      req    = 4'b1111;
      bit_in = 4'b0000;
      @(posedge Clock); @(negedge Clock);
      checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL midrst_grant: got %b want 0100", grant); end
      @(posedge Clock); @(negedge Clock);
      for (int j = 0; j < 8; j++) begin
         bit_in = sh[15] ? 4'b0100 : 4'b1011;
         sh     = sh << 1;
         @(posedge Clock); @(negedge Clock);
      end
      Reset = 1'b1;
      #1;
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL midrst_grant_clr: got %b want 0000", grant); end
      checks++; if ({busy, done, det_clr, aborted} !== 4'b0000) begin errors++; $display("FAIL midrst_flags: got %b want 0000", {busy, done, det_clr, aborted}); end
      checks++; if (hit_count !== 5'd0) begin errors++; $display("FAIL midrst_hits: got %0d want 0", hit_count); end
      checks++; if (done_ch !== 2'd0) begin errors++; $display("FAIL midrst_done_ch: got %0d want 0", done_ch); end
      @(posedge Clock); @(negedge Clock);
      Reset  = 1'b0;
      bit_in = 4'b0000;
      @(posedge Clock); @(negedge Clock);
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL midrst_first_grant: got %b want 0001", grant); end
      checks++; if (det_clr !== 1'b1) begin errors++; $display("FAIL midrst_clr: got %b want 1", det_clr); end
   endtask

   task automatic test_saturation();
      apply_reset();
      run_frame("sat_wide", 2'd0, 4'b0001, 16'b1101_1101_1101_1101, 5'd4);
      checks++; if (s_hit_count !== 2'd3) begin errors++; $display("FAIL sat_hits: got %0d want 3", s_hit_count); end
      checks++; if (s_done_ch !== 2'd0) begin errors++; $display("FAIL sat_done_ch: got %0d want 0", s_done_ch); end
      checks++; if ({s_aborted, s_busy, s_done, s_grant} !== 7'b0000000) begin errors++; $display("FAIL sat_idle: got %b want 0000000", {s_aborted, s_busy, s_done, s_grant}); end
      req = 4'b0000;
   endtask

   initial begin
      test_reset();
      test_single();
      test_all_channels();
      test_rr_wrap();
      test_abort();
      test_reset_mid_run();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/detector_frame_scheduler.md
Name: detector_frame_scheduler

Overview:
- Time-shares one serial "1101" Mealy sequence detector among N_CH serial requesters, one fixed-length frame at a time.
- Detector port mapping: Clock to Clock, det_clr ORed with system Reset to detector Reset, det_w to w, z to det_z.
- Arbitrates round-robin, clears the detector before each frame and steers the granted channel's bit stream into it.
- Counts detector hits per frame and reports the result with a one-cycle done pulse.

Parameters:
N_CH, 4, number of requesting channels (2..8)
FRAME_LEN, 16, bits per frame fed to detector (>=2)
CNT_W, 5, width of hit counter (saturating)

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
req  in  N_CH  per-channel frame request, level; must hold for the whole frame
bit_in  in  N_CH  per-channel serial data bit, sampled while granted
det_z  in  1  detector Mealy output (combinational from det_w and detector state)
det_w  out  1  serial bit to detector
det_clr  out  1  registered detector clear pulse
grant  out  N_CH  one-hot grant, registered
busy  out  1  high in CLEAR, RUN or REPORT
done  out  1  one-cycle frame-complete pulse
done_ch  out  $clog2(N_CH)  channel of last reported frame
hit_count  out  CNT_W  hits in last reported frame
aborted  out  1  last reported frame ended early

Behaviour:
- Reset values (asynchronous): state=IDLE, grant=0, det_clr=0, done=0, busy=0, hit_count=0, done_ch=0, aborted=0, bit counter=0, rr pointer=N_CH-1.
- Channel 0 has first priority after reset.
- FSM states: IDLE, CLEAR, RUN, REPORT.
- IDLE:
  - If any req bit is set, select the first set bit searching from rr+1 upward with wrap-around.
  - Register grant one-hot and the selected channel; rr <= selected channel; go to CLEAR.
  - If no req bit is set, stay in IDLE.
- CLEAR (1 cycle):
  - det_clr=1, grant held, det_w=0.
  - Bit counter and internal hit accumulator reset to 0; go to RUN.
- RUN:
  - det_w = bit_in[selected], combinational, same cycle.
  - At each edge with req[selected]=1: bit counter +1; if det_z=1, accumulator +1, saturating at 2^CNT_W-1.
  - When the bit counter reaches FRAME_LEN-1 at an edge with req held, the last bit is counted and the FSM goes to REPORT.
  - If req[selected]=0 at an edge: that cycle's bit and det_z are not counted; aborted flag is set; go to REPORT.
- REPORT (1 cycle):
  - done=1; hit_count <= accumulator, done_ch <= selected, aborted <= flag.
  - grant cleared at the exit edge; go to IDLE.
- Outside RUN, det_w=0, which holds the detector in its default state.
- hit_count, done_ch and aborted hold until the next REPORT.
- Latency:
  - A req seen in IDLE at edge k gives grant and det_clr visible after k, and the first RUN cycle after k+1.
  - A full frame occupies FRAME_LEN+3 cycles (IDLE, CLEAR, RUN×FRAME_LEN, REPORT).
  - Back-to-back frames always pass through IDLE.
- req changes on non-selected channels during a frame are ignored; arbitration happens only in IDLE.
- Detector semantics: non-overlapping; after z=1 or any mismatch it returns to default. Every frame starts clean because of CLEAR.
- Reset mid-frame aborts immediately with no done pulse.

Test Plan:
- Bench uses a detector model with the stated semantics.
- Single channel: req[0]=1, bit_in[0] stream 1101 1101 0000 0000 -> grant=0001 and det_clr pulse 1 cycle after req; done 18 cycles after req with hit_count=2, done_ch=0, aborted=0.
- All four channels: req=1111 held, each stream 1101 0..0 -> frames granted in order 0,1,2,3; done pulses 19 cycles apart, each with hit_count=1.
- Round-robin wrap: after ch2 is served, req=0101 -> next grant=0001 (ch0), then ch2.
- Abort: req[1] dropped after 5 counted bits of stream 11011... -> REPORT next cycle with aborted=1, hit_count=1, done_ch=1; grant=0 afterwards.
- Reset mid-RUN: assert Reset at bit 8 -> grant, busy, done and hit_count go to 0 without waiting for a clock edge; after release, with req=1111, ch0 is granted first.
- Saturation: CNT_W=2, FRAME_LEN=16, stream 1101 repeated 4 times -> hit_count=3.
